// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-lite control sequencer: steps fetch/decode/exec/mem/wb,
// stalls on the mem_ready handshake, and traps on illegal opcodes or memory timeouts.
// Ports:
//   clk, rst_n (sync, active-low)
//   opcode, alu_zero, mem_ready in
//   datapath controls, trap, trap_cause, state out
module mc_control_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       link,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    R_WB     = 4'd4,
    I_WB     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    JSP_ADDR = 4'd12,
    JSP_RD   = 4'd13,
    TRAP     = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_NORI = 6'b001101;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JSP  = 6'b010010;

  localparam logic [8:0] TO = 9'(TIMEOUT);

  state_t     st;
  logic [7:0] wcnt;
  logic       trap_q;
  logic [1:0] cause_q;
  logic       mem_state;
  logic [8:0] wnext;
  logic       to_hit;

  // The zero flag gates pc_write_cond inside the datapath.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign mem_state = (st == FETCH) || (st == MEM_RD) ||
                     (st == MEM_WR) || (st == JSP_RD);
  assign wnext  = {1'b0, wcnt} + 9'd1;
  // Ready in the same cycle as the limit wins; only a miss traps.
  assign to_hit = (wnext >= TO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= FETCH;
      wcnt    <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      // Counter survives only while a request keeps stalling.
      wcnt <= '0;
      if (mem_state && !mem_ready) begin
        if (to_hit) begin
          st      <= TRAP;
          trap_q  <= 1'b1;
          cause_q <= 2'd2;
        end else begin
          wcnt <= wnext[7:0];
        end
      end else begin
        unique case (st)
          FETCH: st <= DECODE;
          DECODE: begin
            unique case (opcode)
              OP_R:          st <= EXEC_R;
              OP_NORI:       st <= EXEC_I;
              OP_LW, OP_SW:  st <= MEM_ADDR;
              OP_BEQ:        st <= BRANCH;
              OP_JAL:        st <= JAL;
              OP_JSP:        st <= JSP_ADDR;
              default: begin
                st      <= TRAP;
                trap_q  <= 1'b1;
                cause_q <= 2'd1;
              end
            endcase
          end
          EXEC_R:   st <= R_WB;
          EXEC_I:   st <= I_WB;
          MEM_ADDR: st <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
          MEM_RD:   st <= MEM_WB;
          JSP_ADDR: st <= JSP_RD;
          TRAP:     st <= TRAP;
          R_WB, I_WB, MEM_WB, MEM_WR,
          BRANCH, JAL, JSP_RD: st <= FETCH;
          default:  st <= FETCH;
        endcase
      end
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    link          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    unique case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'd3;
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      R_WB: begin
        reg_dst   = 2'd1;
        reg_write = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = 2'd3;
      end
      I_WB: reg_write = 1'b1;
      MEM_ADDR, JSP_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      JAL: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        reg_write = 1'b1;
        reg_dst   = 2'd2;
        link      = 1'b1;
      end
      JSP_RD: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        pc_source = 2'd3;
        pc_write  = mem_ready;
      end
      default: ;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm (TIMEOUT=4): per-cycle expected control words
// are queued as stimulus is driven and compared at the falling edge.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d;
  logic       mem_read, mem_write, mem_to_reg, reg_write, link;
  logic       alu_src_a, trap;
  logic [1:0] pc_source, reg_dst, alu_src_b, alu_op, trap_cause;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write),
    .link(link), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .trap(trap), .trap_cause(trap_cause),
    .state(state)
  );

  localparam logic [3:0] F = 4'd0, D = 4'd1;
  localparam logic [3:0] XR = 4'd2, XI = 4'd3;
  localparam logic [3:0] RW = 4'd4, IW = 4'd5;
  localparam logic [3:0] MA = 4'd6, MR = 4'd7;
  localparam logic [3:0] MB = 4'd8, MW = 4'd9;
  localparam logic [3:0] BR = 4'd10, JL = 4'd11;
  localparam logic [3:0] JA = 4'd12, JR = 4'd13;
  localparam logic [3:0] TR = 4'd14;

  localparam logic [5:0] R_OP = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] NORI = 6'b001101;
  localparam logic [5:0] JALO = 6'b000011;
  localparam logic [5:0] JSP  = 6'b010010;
  localparam logic [5:0] ILL  = 6'b111111;

  logic [24:0] obs;
  assign obs = {pc_write, pc_write_cond, pc_source, ir_write,
                i_or_d, mem_read, mem_write, mem_to_reg,
                reg_dst, reg_write, link, alu_src_a,
                alu_src_b, alu_op, trap, trap_cause, state};

  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] sb_q[$];
  string       tag_q[$];

  task automatic chk(input string tag,
                     input logic [24:0] got,
                     input logic [24:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] exp_word(
      input logic [3:0] st, input logic rdy,
      input logic [1:0] cause);
    logic pw, pwc, irw, iod, mrd, mwr, m2r, rw, lk, sa;
    logic [1:0] ps, rd, sb, op;
    {pw, pwc, irw, iod, mrd, mwr, m2r, rw, lk, sa} = '0;
    {ps, rd, sb, op} = '0;
    case (st)
      F:  begin mrd = 1; sb = 1; irw = rdy; pw = rdy; end
      D:  sb = 3;
      XR: begin sa = 1; op = 2; end
      RW: begin rd = 1; rw = 1; end
      XI: begin sa = 1; sb = 2; op = 3; end
      IW: rw = 1;
      MA: begin sa = 1; sb = 2; end
      MR: begin mrd = 1; iod = 1; end
      MB: begin m2r = 1; rw = 1; end
      MW: begin mwr = 1; iod = 1; end
      BR: begin sa = 1; op = 1; pwc = 1; ps = 1; end
      JL: begin pw = 1; ps = 2; rw = 1; rd = 2; lk = 1; end
      JA: begin sa = 1; sb = 2; end
      JR: begin mrd = 1; iod = 1; ps = 3; pw = rdy; end
      default: ;
    endcase
    return {pw, pwc, ps, irw, iod, mrd, mwr, m2r, rd, rw,
            lk, sa, sb, op, (cause != 2'd0), cause, st};
  endfunction

  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic rdy, input logic [5:0] op,
                     input logic z = 1'b0, input logic rn = 1'b1,
                     input logic [1:0] cause = 2'd0);
    opcode    = op;
    mem_ready = rdy;
    alu_zero  = z;
    rst_n     = rn;
    sb_q.push_back(exp_word(st, rdy, cause));
    tag_q.push_back(tag);
    @(negedge clk);
    chk(tag_q.pop_front(), obs, sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = R_OP; alu_zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_fetch", F, 1'b0, R_OP);
    cyc("r_fetch", F, 1'b1, R_OP);
    cyc("r_dec", D, 1'b1, R_OP);
    cyc("r_exec", XR, 1'b1, R_OP);
    cyc("r_wb", RW, 1'b1, R_OP);
    cyc("lw_fetch", F, 1'b1, LW);
    cyc("lw_dec", D, 1'b1, LW);
    cyc("lw_addr", MA, 1'b1, LW);
    repeat (3) cyc("lw_stall", MR, 1'b0, LW);
    cyc("lw_rd", MR, 1'b1, LW);
    cyc("lw_wb", MB, 1'b1, LW);
    cyc("sw_fetch", F, 1'b1, SW);
    cyc("sw_dec", D, 1'b1, SW);
    cyc("sw_addr", MA, 1'b1, SW);
    cyc("sw_stall", MW, 1'b0, SW);
    cyc("sw_wr", MW, 1'b1, SW);
    cyc("ni_fetch", F, 1'b1, NORI);
    cyc("ni_dec", D, 1'b1, NORI);
    cyc("ni_exec", XI, 1'b0, NORI);
    cyc("ni_wb", IW, 1'b1, NORI);
    for (int k = 0; k < 2; k++) begin
      cyc("bq_fetch", F, 1'b1, BEQ, 1'(k == 0));
      cyc("bq_dec", D, 1'b1, BEQ, 1'(k == 0));
      cyc("bq_br", BR, 1'b1, BEQ, 1'(k == 0));
    end
    cyc("jal_fetch", F, 1'b1, JALO);
    cyc("jal_dec", D, 1'b1, JALO);
    cyc("jal_link", JL, 1'b1, JALO);
    cyc("jsp_fetch", F, 1'b1, JSP);
    cyc("jsp_dec", D, 1'b1, JSP);
    cyc("jsp_addr", JA, 1'b1, JSP);
    cyc("jsp_stall", JR, 1'b0, JSP);
    cyc("jsp_rd", JR, 1'b1, JSP);
    // reset in the middle of a load
    cyc("mr_fetch", F, 1'b1, LW);
    cyc("mr_dec", D, 1'b1, LW);
    cyc("mr_addr", MA, 1'b1, LW, 1'b0, 1'b0);
    cyc("mr_after", F, 1'b0, R_OP);
    cyc("mr_fetch2", F, 1'b1, R_OP);
    cyc("mr_dec2", D, 1'b1, R_OP);
    cyc("mr_exec", XR, 1'b1, R_OP);
    cyc("mr_wb", RW, 1'b1, R_OP);
    // load that never completes
    cyc("lt_fetch", F, 1'b1, LW);
    cyc("lt_dec", D, 1'b1, LW);
    cyc("lt_addr", MA, 1'b1, LW);
    repeat (4) cyc("lt_stall", MR, 1'b0, LW);
    cyc("lt_trap", TR, 1'b1, LW, 1'b0, 1'b1, 2'd2);
    cyc("lt_rst", TR, 1'b0, LW, 1'b0, 1'b0, 2'd2);
    // illegal opcode
    cyc("il_fetch", F, 1'b1, ILL);
    cyc("il_dec", D, 1'b1, ILL);
    repeat (20)
      cyc("il_trap", TR, 1'($urandom_range(0, 1)), ILL,
          1'($urandom_range(0, 1)), 1'b1, 2'd1);
    cyc("il_rst", TR, 1'b0, ILL, 1'b0, 1'b0, 2'd1);
    // fetch timeout
    repeat (4) cyc("to_wait", F, 1'b0, R_OP);
    repeat (3) cyc("to_trap", TR, 1'b1, R_OP, 1'b0, 1'b1, 2'd2);
    cyc("to_rst", TR, 1'b0, R_OP, 1'b0, 1'b0, 2'd2);
    // ready on the limit cycle
    repeat (3) cyc("ok_wait", F, 1'b0, R_OP);
    cyc("ok_hit", F, 1'b1, R_OP);
    cyc("ok_dec", D, 1'b1, R_OP);
    cyc("ok_exec", XR, 1'b1, R_OP);
    cyc("ok_wb", RW, 1'b1, R_OP);
    cyc("ok_end", F, 1'b0, R_OP);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
